decoder_proj_fv: RTL and testbench

Registered multi-mode 4-bit decoder driven by a single 7-bit packed input bus (strobe, mode, value).
Produces a one-hot / priority-encoded word, a 7-segment pattern, an error flag and a saturating strobe counter.
Sits behind the project I/O pads as the decoder core exercised by the formal/cover harness.

---
 rtl/decoder_proj_fv_if.sv | 28 ++
 rtl/decoder_proj_fv.sv | 161 ++++++++++++++++
 tb/tb_decoder_proj_fv.sv | 117 +++++++++++
 3 files changed

// File: rtl/decoder_proj_fv_if.sv
// decoder_proj_fv_if: packed input bus plus registered result bus of the
// decoder core. The master side drives io_in and observes the results. The
// slave side, which is the decoder, samples io_in and drives the results.
//
// Handshake: io_in[6] is a valid-only strobe with no ready. The decoder
// accepts every strobe that is high at a rising clk edge. out_valid pulses
// for exactly the cycle after each accepted strobe. The results it
// qualifies hold their values until the next accepted strobe.
interface decoder_proj_fv_if #(
    parameter int CNT_W = 8
);
    logic [6:0]       io_in;
    logic [15:0]      dec_out;
    logic [6:0]       seg_out;
    logic             out_valid;
    logic             err;
    logic [CNT_W-1:0] strobe_cnt;

    modport master (
        output io_in,
        input  dec_out, seg_out, out_valid, err, strobe_cnt
    );

    modport slave (
        input  io_in,
        output dec_out, seg_out, out_valid, err, strobe_cnt
    );
endinterface

// File: rtl/decoder_proj_fv.sv
// decoder_proj_fv: registered multi-mode 4-bit decoder.
// io_in = {strobe, mode[1:0], value[3:0]}.
// Modes: 00 one-hot, 01 hex, 10 BCD, 11 priority.
// Every result is registered one clock after the strobe is sampled.
// There is no combinational path from io_in to any output.
// Optional macro DECODER_PROJ_FORMAL_EN adds assertions and cover points.
// Functional behaviour is the same with or without the macro.
module decoder_proj_fv #(
    parameter int CNT_W          = 8,
    parameter bit SEG_ACTIVE_LOW = 1'b0
) (
    input logic              clk,
    input logic              rst_n,
    decoder_proj_fv_if.slave bus
);
    // Blank pattern as it appears on the pins. This is also the reset value.
    localparam logic [6:0] SEG_BLANK = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;

    logic             w_strobe;
    logic [1:0]       w_mode;
    logic [3:0]       w_value;
    logic [1:0]       w_idx;
    logic [15:0]      w_dec;
    logic [6:0]       w_seg_hi;
    logic [6:0]       w_seg;
    logic             w_err;

    logic [15:0]      r_dec;
    logic [6:0]       r_seg;
    logic             r_valid;
    logic             r_err;
    logic [CNT_W-1:0] r_cnt;

    assign w_strobe = bus.io_in[6];
    assign w_mode   = bus.io_in[5:4];
    assign w_value  = bus.io_in[3:0];

    // Active-high hex glyph, bit order {g,f,e,d,c,b,a}.
    function automatic logic [6:0] f_glyph(input logic [3:0] d);
        case (d)
            4'h0: f_glyph = 7'h3F;
            4'h1: f_glyph = 7'h06;
            4'h2: f_glyph = 7'h5B;
            4'h3: f_glyph = 7'h4F;
            4'h4: f_glyph = 7'h66;
            4'h5: f_glyph = 7'h6D;
            4'h6: f_glyph = 7'h7D;
            4'h7: f_glyph = 7'h07;
            4'h8: f_glyph = 7'h7F;
            4'h9: f_glyph = 7'h6F;
            4'hA: f_glyph = 7'h77;
            4'hB: f_glyph = 7'h7C;
            4'hC: f_glyph = 7'h39;
            4'hD: f_glyph = 7'h5E;
            4'hE: f_glyph = 7'h79;
            default: f_glyph = 7'h71;
        endcase
    endfunction

    // Index of the highest set bit of value. A zero value is flagged separately.
    always_comb begin
        w_idx = 2'd0;
        casez (w_value)
            4'b1???: w_idx = 2'd3;
            4'b01??: w_idx = 2'd2;
            4'b001?: w_idx = 2'd1;
            default: w_idx = 2'd0;
        endcase
    end

    // Mode decode into the next dec/seg/err values, active-high segments.
    always_comb begin
        w_dec    = 16'h0000;
        w_seg_hi = 7'h00;
        w_err    = 1'b0;
        case (w_mode)
            2'b00: begin
                w_dec    = 16'h0001 << w_value;
                w_seg_hi = f_glyph(w_value);
            end
            2'b01: begin
                w_dec    = {12'h000, w_value};
                w_seg_hi = f_glyph(w_value);
            end
            2'b10: begin
                if (w_value <= 4'd9) begin
                    w_dec    = {12'h000, w_value};
                    w_seg_hi = f_glyph(w_value);
                end else begin
                    w_err = 1'b1;
                end
            end
            default: begin
                if (w_value != 4'd0) begin
                    w_dec    = 16'h0001 << w_idx;
                    w_seg_hi = f_glyph({2'b00, w_idx});
                end else begin
                    w_err = 1'b1;
                end
            end
        endcase
    end

    // Polarity is applied before the register, so the blank pattern inverts too.
    assign w_seg = SEG_ACTIVE_LOW ? ~w_seg_hi : w_seg_hi;

    // Result registers load only on a strobe; out_valid follows the strobe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_dec   <= 16'h0000;
            r_seg   <= SEG_BLANK;
            r_err   <= 1'b0;
            r_valid <= 1'b0;
        end else begin
            r_valid <= w_strobe;
            if (w_strobe) begin
                r_dec <= w_dec;
                r_seg <= w_seg;
                r_err <= w_err;
            end
        end
    end

    // Count of accepted strobes. It sticks at all-ones and does not wrap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (w_strobe && (r_cnt != {CNT_W{1'b1}})) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign bus.dec_out    = r_dec;
    assign bus.seg_out    = r_seg;
    assign bus.err        = r_err;
    assign bus.out_valid  = r_valid;
    assign bus.strobe_cnt = r_cnt;

`ifdef DECODER_PROJ_FORMAL_EN
    // A strobe in mode 00 or 11 produces a one-hot or zero word on the next cycle.
    a_onehot: assert property (@(posedge clk) disable iff (!rst_n)
        (w_strobe && (w_mode == 2'b00 || w_mode == 2'b11)) |=> $onehot0(bus.dec_out));

    // An error result always carries a blank segment pattern.
    a_err_blank: assert property (@(posedge clk) disable iff (!rst_n)
        bus.err |-> (bus.seg_out == SEG_BLANK));

    // out_valid is high only after a strobe was sampled, including the first cycle after reset.
    a_valid_src: assert property (@(posedge clk) disable iff (!rst_n)
        bus.out_valid |-> $past(w_strobe));

    // The strobe counter never decreases while reset is inactive.
    a_cnt_mono: assert property (@(posedge clk) disable iff (!rst_n)
        1'b1 |=> (bus.strobe_cnt >= $past(bus.strobe_cnt)));

    c_mode0: cover property (@(posedge clk) disable iff (!rst_n) w_strobe && w_mode == 2'b00);
    c_mode1: cover property (@(posedge clk) disable iff (!rst_n) w_strobe && w_mode == 2'b01);
    c_mode2: cover property (@(posedge clk) disable iff (!rst_n) w_strobe && w_mode == 2'b10);
    c_mode3: cover property (@(posedge clk) disable iff (!rst_n) w_strobe && w_mode == 2'b11);
`endif
endmodule

// File: tb/tb_decoder_proj_fv.sv
// tb_decoder_proj_fv: directed-vector bench for decoder_proj_fv with default parameters.
module tb_decoder_proj_fv;
    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    decoder_proj_fv_if #(.CNT_W(8)) bus ();

    decoder_proj_fv #(.CNT_W(8), .SEG_ACTIVE_LOW(1'b0)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // single checking task
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic [15:0] dec, input logic [6:0] seg,
                             input logic err, input logic vld, input logic [7:0] cnt);
        check({tag, ".dec"}, 32'(bus.dec_out), 32'(dec));
        check({tag, ".seg"}, 32'(bus.seg_out), 32'(seg));
        check({tag, ".err"}, 32'(bus.err), 32'(err));
        check({tag, ".vld"}, 32'(bus.out_valid), 32'(vld));
        check({tag, ".cnt"}, 32'(bus.strobe_cnt), 32'(cnt));
    endtask

    // driver: apply io_in at the falling edge, then sample 1 ns after the rising edge
    task automatic step(input logic [6:0] v);
        @(negedge clk);
        bus.io_in = v;
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst_n    = 1'b0;
        bus.io_in = 7'h00;
        #12;
        check_all("reset", 16'h0000, 7'h00, 1'b0, 1'b0, 8'd0);

        @(negedge clk);
        rst_n = 1'b1;
        step(7'b0000000);
        check_all("idle", 16'h0000, 7'h00, 1'b0, 1'b0, 8'd0);

        step(7'b1001000);
        check_all("m0_v8", 16'h0100, 7'h7F, 1'b0, 1'b1, 8'd1);
        step(7'b0001000);
        check_all("m0_pulse_end", 16'h0100, 7'h7F, 1'b0, 1'b0, 8'd1);

        step(7'b1011010);
        check_all("m1_vA", 16'h000A, 7'h77, 1'b0, 1'b1, 8'd2);
        step(7'b0011010);
        check_all("m1_hold", 16'h000A, 7'h77, 1'b0, 1'b0, 8'd2);

        step(7'b1101100);
        check_all("m2_v12", 16'h0000, 7'h00, 1'b1, 1'b1, 8'd3);
        step(7'b1100111);
        check_all("m2_v7", 16'h0007, 7'h07, 1'b0, 1'b1, 8'd4);
        step(7'b1101001);
        check_all("m2_v9", 16'h0009, 7'h6F, 1'b0, 1'b1, 8'd5);

        step(7'b1110110);
        check_all("m3_v6", 16'h0004, 7'h5B, 1'b0, 1'b1, 8'd6);
        step(7'b1110000);
        check_all("m3_v0", 16'h0000, 7'h00, 1'b1, 1'b1, 8'd7);
        step(7'b1110001);
        check_all("m3_v1", 16'h0001, 7'h3F, 1'b0, 1'b1, 8'd8);
        step(7'b1111000);
        check_all("m3_v8", 16'h0008, 7'h4F, 1'b0, 1'b1, 8'd9);

        step(7'b1001111);
        check_all("m0_vF", 16'h8000, 7'h71, 1'b0, 1'b1, 8'd10);
        step(7'b1000000);
        check_all("m0_v0", 16'h0001, 7'h3F, 1'b0, 1'b1, 8'd11);

        // Back-to-back strobes: out_valid must stay high and the counter must saturate.
        for (int i = 0; i < 300; i++) begin
            step(7'b1011101);
            check("b2b.vld", 32'(bus.out_valid), 32'd1);
        end
        check_all("sat", 16'h000D, 7'h5E, 1'b0, 1'b1, 8'd255);

        // Asynchronous reset asserted between clock edges.
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check_all("async_rst", 16'h0000, 7'h00, 1'b0, 1'b0, 8'd0);

        // Release with strobe high: nothing may change until the next rising edge.
        @(negedge clk);
        bus.io_in = 7'b1010011;
        rst_n = 1'b1;
        #1;
        check_all("rel_pre_edge", 16'h0000, 7'h00, 1'b0, 1'b0, 8'd0);
        @(posedge clk);
        #1;
        check_all("rel_first", 16'h0003, 7'h4F, 1'b0, 1'b1, 8'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
